// File: rtl/clk_gen_bank_pkg.sv
// Shared types and width helpers for the clk_gen_bank divided-clock generator.
package clk_gen_pkg;

   typedef enum logic [1:0] {
      LOCKED,
      PENDING,
      SETTLING
   } state_e;

   // Settle counter runs 0..cycles-1.
   function automatic int settle_w(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

   function automatic int ch_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/clk_gen_bank_if.sv
// Configuration handshake bundle for clk_gen_bank.
// cfg_phase exists only when CLK_GEN_PHASE_EN is defined.
interface clk_gen_bank_if
   import clk_gen_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DIV_W  = 16
);
   localparam int CH_W = ch_w(NUM_CH);

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
   logic [DIV_W-1:0] cfg_hi;
`ifdef CLK_GEN_PHASE_EN
   logic [DIV_W-1:0] cfg_phase;

   modport master (output cfg_valid, cfg_ch, cfg_div, cfg_hi, cfg_phase, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_hi, cfg_phase, output cfg_ready);
`else
   modport master (output cfg_valid, cfg_ch, cfg_div, cfg_hi, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_hi, output cfg_ready);
`endif

endinterface

// File: rtl/clk_gen_channel.sv
// One divided-clock channel: counter, div/hi storage, wrap-aligned reload, registered outputs.
// Phase start and sync reload exist only when CLK_GEN_PHASE_EN is defined.
module clk_gen_channel #(
   parameter int DIV_W       = 16,
   parameter int DEFAULT_DIV = 2,
   parameter int DEFAULT_HI  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] div_i,
   input  logic [DIV_W-1:0] hi_i,
`ifdef CLK_GEN_PHASE_EN
   input  logic [DIV_W-1:0] phase_i,
   input  logic             sync_i,
`endif
   output logic             stopped_o,
   output logic             wrap_o,
   output logic             clk_out_o,
   output logic             tick_o
);
   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

   logic [DIV_W-1:0] div_q, div_d, hi_q, hi_d, cnt_q, cnt_d, start_val;
   logic             clk_q, clk_d, tick_q, tick_d, running, wrap;
`ifdef CLK_GEN_PHASE_EN
   logic [DIV_W-1:0] phase_q, phase_d;
`endif

   always_comb begin
      running = en_i && (div_q != '0);
      wrap    = running && (cnt_q == div_q - ONE);
`ifdef CLK_GEN_PHASE_EN
      start_val = (phase_i >= div_i) ? '0 : phase_i;
      phase_d   = load_i ? start_val : phase_q;
`else
      start_val = '0;
`endif
      div_d  = load_i ? div_i : div_q;
      hi_d   = load_i ? hi_i : hi_q;
      clk_d  = running && (cnt_q < hi_q);
      tick_d = wrap;
      cnt_d  = cnt_q + ONE;
      // Loads arrive only on a wrap or while stopped, so a restart never truncates a period.
      if (load_i)        cnt_d = start_val;
      else if (!running) cnt_d = '0;
`ifdef CLK_GEN_PHASE_EN
      else if (sync_i)   cnt_d = phase_q;
`endif
      else if (wrap)     cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q   <= DIV_W'(DEFAULT_DIV);
         hi_q    <= DIV_W'(DEFAULT_HI);
         cnt_q   <= '0;
         clk_q   <= 1'b0;
         tick_q  <= 1'b0;
`ifdef CLK_GEN_PHASE_EN
         phase_q <= '0;
`endif
      end else begin
         div_q   <= div_d;
         hi_q    <= hi_d;
         cnt_q   <= cnt_d;
         clk_q   <= clk_d;
         tick_q  <= tick_d;
`ifdef CLK_GEN_PHASE_EN
         phase_q <= phase_d;
`endif
      end
   end

   assign stopped_o = !running;
   assign wrap_o    = wrap;
   assign clk_out_o = clk_q;
   assign tick_o    = tick_q;

endmodule

// File: rtl/clk_gen_bank.sv
// Bank of NUM_CH programmable divided clocks with a locked/settle reconfiguration FSM.
// Optional macro CLK_GEN_PHASE_EN adds per-channel start phase and the sync_all input.
module clk_gen_bank
   import clk_gen_pkg::*;
#(
   parameter int NUM_CH        = 4,
   parameter int DIV_W         = 16,
   parameter int DEFAULT_DIV   = 2,
   parameter int DEFAULT_HI    = 1,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   clk_gen_bank_if.slave     cfg,
   input  logic [NUM_CH-1:0] ch_en,
`ifdef CLK_GEN_PHASE_EN
   input  logic              sync_all,
`endif
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic              locked
);
   localparam int CH_W = ch_w(NUM_CH);
   localparam int SW   = settle_w(SETTLE_CYCLES);
   localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [CH_W:0]   NUM_CH_L    = (CH_W + 1)'(NUM_CH);

   state_e            state_q, state_d;
   logic [SW-1:0]     settle_q, settle_d;
   logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
   logic [DIV_W-1:0]  pend_div_q, pend_div_d, pend_hi_q, pend_hi_d;
   logic [NUM_CH-1:0] stopped, wrap, load_vec;
   logic              load_fire, ch_ok, capture;
`ifdef CLK_GEN_PHASE_EN
   logic [DIV_W-1:0]  pend_phase_q, pend_phase_d;
   logic              sync_fire;
`endif

   assign ch_ok = {1'b0, cfg.cfg_ch} < NUM_CH_L;

   always_comb begin
      state_d       = state_q;
      settle_d      = settle_q;
      load_fire     = 1'b0;
      capture       = 1'b0;
      locked        = 1'b0;
      cfg.cfg_ready = 1'b0;
`ifdef CLK_GEN_PHASE_EN
      sync_fire     = 1'b0;
`endif
      unique case (state_q)
         LOCKED: begin
            locked        = 1'b1;
            cfg.cfg_ready = 1'b1;
            // Out-of-range channel writes complete the handshake but change nothing.
            if (cfg.cfg_valid && ch_ok) begin
               capture = 1'b1;
               state_d = PENDING;
            end
`ifdef CLK_GEN_PHASE_EN
            else if (sync_all) begin
               sync_fire = 1'b1;
               state_d   = SETTLING;
               settle_d  = '0;
            end
`endif
         end
         PENDING: begin
            if (stopped[pend_ch_q] || wrap[pend_ch_q]) begin
               load_fire = 1'b1;
               state_d   = SETTLING;
               settle_d  = '0;
            end
         end
         SETTLING: begin
            if (settle_q == SETTLE_LAST) state_d = LOCKED;
            else                         settle_d = settle_q + SW'(1);
         end
         default: state_d = SETTLING;
      endcase
   end

   always_comb begin
      pend_ch_d  = capture ? cfg.cfg_ch : pend_ch_q;
      pend_div_d = capture ? cfg.cfg_div : pend_div_q;
      pend_hi_d  = capture ? cfg.cfg_hi : pend_hi_q;
`ifdef CLK_GEN_PHASE_EN
      pend_phase_d = capture ? cfg.cfg_phase : pend_phase_q;
`endif
      load_vec = '0;
      for (int i = 0; i < NUM_CH; i++) load_vec[i] = load_fire && (pend_ch_q == CH_W'(i));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= SETTLING;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
      end
   end

   // Pending payload is qualified by state_q, so it needs no reset.
   always_ff @(posedge clk) begin
      pend_ch_q  <= pend_ch_d;
      pend_div_q <= pend_div_d;
      pend_hi_q  <= pend_hi_d;
`ifdef CLK_GEN_PHASE_EN
      pend_phase_q <= pend_phase_d;
`endif
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_gen_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV),
         .DEFAULT_HI  (DEFAULT_HI)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .en_i      (ch_en[g]),
         .load_i    (load_vec[g]),
         .div_i     (pend_div_q),
         .hi_i      (pend_hi_q),
`ifdef CLK_GEN_PHASE_EN
         .phase_i   (pend_phase_q),
         .sync_i    (sync_fire),
`endif
         .stopped_o (stopped[g]),
         .wrap_o    (wrap[g]),
         .clk_out_o (clk_out[g]),
         .tick_o    (tick[g])
      );
   end

endmodule

// File: tb/tb_clk_gen_bank.sv
// Self-checking bench for clk_gen_bank: period-arithmetic reference model, directed and random steps.
// Three channels are used so a 2-bit cfg_ch can address a non-existent channel.
module tb_clk_gen_bank;
   localparam int NUM_CH  = 3;
   localparam int CH_W    = 2;
   localparam int DIV_W   = 16;
   localparam int DEF_DIV = 2;
   localparam int DEF_HI  = 1;
   localparam int SETTLE  = 16;

   logic              clk = 1'b0;
   logic              reset;
   logic [NUM_CH-1:0] ch_en;
   logic [NUM_CH-1:0] clk_out, tick;
   logic              locked;
`ifdef CLK_GEN_PHASE_EN
   logic              sync_all;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   clk_gen_bank_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) cfg_if ();

   clk_gen_bank #(
      .NUM_CH        (NUM_CH),
      .DIV_W         (DIV_W),
      .DEFAULT_DIV   (DEF_DIV),
      .DEFAULT_HI    (DEF_HI),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cfg      (cfg_if),
      .ch_en    (ch_en),
`ifdef CLK_GEN_PHASE_EN
      .sync_all (sync_all),
`endif
      .clk_out  (clk_out),
      .tick     (tick),
      .locked   (locked)
   );

   // Reference model: each channel's waveform is (cycle - start) mod div against hi.
   longint cyc = 0;
   longint m_start [NUM_CH];
   int     m_div   [NUM_CH];
   int     m_hi    [NUM_CH];
   int     m_ph    [NUM_CH];
   bit     m_pend  = 1'b0;
   int     m_settle = SETTLE;
   int     p_ch, p_div, p_hi, p_ph;
   bit     accepted;

   task automatic step();
      logic [NUM_CH-1:0] nclk, ntick;
      bit  ready_now, run, sy, ok_ch;
      int  pos;
      logic e_locked;
      sy = 1'b0;
`ifdef CLK_GEN_PHASE_EN
      sy = sync_all;
`endif
      ready_now = !m_pend && (m_settle == 0);
      accepted  = cfg_if.cfg_valid && ready_now;
      ok_ch     = int'(cfg_if.cfg_ch) < NUM_CH;
      sy        = sy && ready_now && !(accepted && ok_ch);
      if (!m_pend && m_settle > 0) m_settle--;
      for (int i = 0; i < NUM_CH; i++) begin
         run      = ch_en[i] && (m_div[i] != 0);
         pos      = run ? int'((cyc - m_start[i]) % longint'(m_div[i])) : 0;
         nclk[i]  = run && (pos < m_hi[i]);
         ntick[i] = run && (pos == m_div[i] - 1);
         if (m_pend && p_ch == i && (!run || pos == m_div[i] - 1)) begin
            m_div[i]   = p_div;
            m_hi[i]    = p_hi;
            m_ph[i]    = (p_ph >= p_div) ? 0 : p_ph;
            m_start[i] = cyc + 1 - m_ph[i];
            m_pend     = 1'b0;
            m_settle   = SETTLE;
         end else if (!run) begin
            m_start[i] = cyc + 1;
         end else if (sy) begin
            m_start[i] = cyc + 1 - m_ph[i];
         end
      end
      if (accepted && ok_ch) begin
         m_pend = 1'b1;
         p_ch   = int'(cfg_if.cfg_ch);
         p_div  = int'(cfg_if.cfg_div);
         p_hi   = int'(cfg_if.cfg_hi);
         p_ph   = 0;
`ifdef CLK_GEN_PHASE_EN
         p_ph   = int'(cfg_if.cfg_phase);
`endif
      end
      if (sy) m_settle = SETTLE;
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            m_div[i]   = DEF_DIV;
            m_hi[i]    = DEF_HI;
            m_ph[i]    = 0;
            m_start[i] = cyc + 1;
         end
         m_pend   = 1'b0;
         m_settle = SETTLE;
         nclk     = '0;
         ntick    = '0;
      end
      e_locked = !m_pend && (m_settle == 0);
      @(posedge clk);
      #1;
      cyc++;
      checks++;
      assert (clk_out === nclk) else begin
         errors++;
         $error("FAIL clk_out cyc=%0d observed=%b expected=%b", cyc, clk_out, nclk);
      end
      checks++;
      assert (tick === ntick) else begin
         errors++;
         $error("FAIL tick cyc=%0d observed=%b expected=%b", cyc, tick, ntick);
      end
      checks++;
      assert (locked === e_locked) else begin
         errors++;
         $error("FAIL locked cyc=%0d observed=%b expected=%b", cyc, locked, e_locked);
      end
      checks++;
      assert (cfg_if.cfg_ready === e_locked) else begin
         errors++;
         $error("FAIL cfg_ready cyc=%0d observed=%b expected=%b", cyc, cfg_if.cfg_ready, e_locked);
      end
   endtask

   task automatic run_cycles(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // Holds cfg_valid until the model sees the transfer; back-to-back calls keep valid high.
   task automatic write_cfg(input int ch, input int dv, input int hi, input int ph);
      int n;
      n = 0;
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = CH_W'(ch);
      cfg_if.cfg_div   = DIV_W'(dv);
      cfg_if.cfg_hi    = DIV_W'(hi);
`ifdef CLK_GEN_PHASE_EN
      cfg_if.cfg_phase = DIV_W'(ph);
`endif
      accepted = 1'b0;
      while (!accepted && n < 200) begin
         step();
         n++;
      end
      checks++;
      assert (accepted) else begin
         errors++;
         $error("FAIL handshake_timeout ch=%0d observed=%0d cycles expected=<200", ch, n);
      end
      cfg_if.cfg_valid = 1'b0;
   endtask

   initial begin
      int idx, dv;
      reset            = 1'b1;
      ch_en            = '1;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_div   = '0;
      cfg_if.cfg_hi    = '0;
`ifdef CLK_GEN_PHASE_EN
      cfg_if.cfg_phase = '0;
      sync_all         = 1'b0;
`endif
      run_cycles(3);
      reset = 1'b0;
      run_cycles(20);

      // Reprogram mid-period, then stop and run at div=1.
      run_cycles(1);
      write_cfg(1, 5, 2, 0);
      run_cycles(40);
      write_cfg(0, 0, 1, 0);
      run_cycles(25);
      write_cfg(0, 1, 1, 0);
      run_cycles(25);

      // Back-to-back requests with cfg_valid held high.
      write_cfg(2, 3, 1, 0);
      write_cfg(2, 7, 4, 0);
      run_cycles(30);

      // Non-existent channel, then reset while a write is pending.
      write_cfg(3, 9, 4, 0);
      run_cycles(5);
      write_cfg(1, 6, 3, 0);
      run_cycles(2);
      reset = 1'b1;
      run_cycles(2);
      reset = 1'b0;
      run_cycles(25);

      // Random configs with enables toggling, including during PENDING.
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < int'($urandom_range(12, 3)); k++) begin
            if ($urandom_range(7, 0) == 0) begin
               idx = int'($urandom_range(NUM_CH - 1, 0));
               ch_en[idx] = ~ch_en[idx];
            end
            step();
         end
         dv = int'($urandom_range(7, 0));
         write_cfg(int'($urandom_range(3, 0)), dv, int'($urandom_range(8, 0)), int'($urandom_range(8, 0)));
      end
      ch_en = '1;
      run_cycles(40);

`ifdef CLK_GEN_PHASE_EN
      write_cfg(0, 4, 2, 0);
      write_cfg(1, 4, 2, 2);
      run_cycles(20);
      sync_all = 1'b1;
      step();
      sync_all = 1'b0;
      run_cycles(24);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
